fpga_bridge_vc_sched: RTL and testbench

FPGA_BRIDGE_VC_SCHED -- requirements
Module: fpga_bridge_vc_sched

---
 rtl/fpga_bridge_vc_sched.sv | 66 ++++++
 tb/tb_fpga_bridge_vc_sched.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fpga_bridge_vc_sched.sv
// fpga_bridge_vc_sched: credit-based round-robin scheduler for three virtual channels onto one link.
// Define FPGA_BRIDGE_VC_SCHED_STATS_EN to enable the per-channel sent-flit counters.
module fpga_bridge_vc_sched #(
   parameter int CREDIT_INIT = 8,
   parameter int CREDIT_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            req_val,
   output logic [2:0]            req_rdy,
   input  logic [2:0]            credit_back,
   output logic                  out_val,
   output logic [1:0]            out_channel,
   output logic [3*CREDIT_W-1:0] credit_cnt,
   output logic                  cred_ovf,
   output logic [95:0]           flit_cnt
);
   localparam logic [CREDIT_W-1:0] INIT = CREDIT_W'(CREDIT_INIT);
   logic [CREDIT_W-1:0] cred [3];
   logic [1:0] last_grant, start, gch;
   logic [2:0] elig, rot, pick, grant;
   for (genvar g = 0; g < 3; g++) begin : g_ch
      assign elig[g] = req_val[g] && cred[g] != '0;
      assign credit_cnt[g*CREDIT_W +: CREDIT_W] = cred[g];
   end
   // Rotate eligibility so the channel after last_grant sits at bit 0, pick lowest, rotate back.
   always_comb begin
      start = last_grant == 2'd3 ? 2'd0 : last_grant;
      rot = start == 2'd1 ? {elig[0], elig[2:1]} : start == 2'd2 ? {elig[1:0], elig[2]} : elig;
      pick = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
      grant = start == 2'd1 ? {pick[1:0], pick[2]} : start == 2'd2 ? {pick[0], pick[2:1]} : pick;
      gch = grant[0] ? 2'd1 : grant[1] ? 2'd2 : grant[2] ? 2'd3 : 2'd0;
      req_rdy = rst ? 3'b000 : grant;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_val <= 1'b0;
         out_channel <= 2'd0;
         last_grant <= 2'd3;
         cred_ovf <= 1'b0;
         for (int k = 0; k < 3; k++) cred[k] <= INIT;
      end else begin
         out_val <= |grant;
         out_channel <= gch;
         if (|grant) last_grant <= gch;
         for (int k = 0; k < 3; k++) begin
            if (grant[k] && !credit_back[k]) cred[k] <= cred[k] - CREDIT_W'(1);
            else if (!grant[k] && credit_back[k]) begin
               if (cred[k] == INIT) cred_ovf <= 1'b1;
               else cred[k] <= cred[k] + CREDIT_W'(1);
            end
         end
      end
   end
`ifdef FPGA_BRIDGE_VC_SCHED_STATS_EN
   logic [31:0] fc [3];
   always_ff @(posedge clk) begin
      for (int k = 0; k < 3; k++) fc[k] <= rst ? 32'd0 : grant[k] ? fc[k] + 32'd1 : fc[k];
   end
   for (genvar g = 0; g < 3; g++) begin : g_fc
      assign flit_cnt[32*g +: 32] = fc[g];
   end
`else
   assign flit_cnt = '0;
`endif
endmodule

// File: tb/tb_fpga_bridge_vc_sched.sv
// tb_fpga_bridge_vc_sched: directed stimulus with a queued expectation per cycle for the link output.
module tb_fpga_bridge_vc_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0] req_val = 3'b000;
   logic [2:0] req_rdy;
   logic [2:0] credit_back = 3'b000;
   logic out_val;
   logic [1:0] out_channel;
   logic [23:0] credit_cnt;
   logic cred_ovf;
   logic [95:0] flit_cnt;
   int checks = 0;
   int errors = 0;
   logic [1:0] expq [$];

   fpga_bridge_vc_sched dut (
      .clk(clk), .rst(rst), .req_val(req_val), .req_rdy(req_rdy),
      .credit_back(credit_back), .out_val(out_val), .out_channel(out_channel),
      .credit_cnt(credit_cnt), .cred_ovf(cred_ovf), .flit_cnt(flit_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [95:0] got, input logic [95:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   // Drive one cycle, check the combinational grant, queue the link output expected next cycle.
   task automatic cyc(input logic [2:0] rv, input logic [2:0] cb, input logic r, input logic [2:0] exp_rdy);
      req_val = rv;
      credit_back = cb;
      rst = r;
      #1;
      check("req_rdy", {93'd0, req_rdy}, {93'd0, exp_rdy});
      @(posedge clk);
      expq.push_back(exp_rdy[0] ? 2'd1 : exp_rdy[1] ? 2'd2 : exp_rdy[2] ? 2'd3 : 2'd0);
      #1;
   endtask

   task automatic chk_cred(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3);
      check("credit_cnt", {72'd0, credit_cnt}, {72'd0, c3, c2, c1});
   endtask

   task automatic chk_flit(input logic [31:0] f1, input logic [31:0] f2, input logic [31:0] f3);
`ifdef FPGA_BRIDGE_VC_SCHED_STATS_EN
      check("flit_cnt", flit_cnt, {f3, f2, f1});
`else
      check("flit_cnt", flit_cnt, {f3, f2, f1} & 96'd0);
`endif
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            logic [1:0] e;
            e = expq.pop_front();
            check("link_out", {93'd0, out_val, out_channel}, {93'd0, e != 2'd0, e});
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdy", {93'd0, req_rdy}, 96'd0);
      rst = 1'b0;
      #1;
      chk_cred(8, 8, 8);
      check("rst_ovf", {95'd0, cred_ovf}, 96'd0);
      check("rst_out", {93'd0, out_val, out_channel}, 96'd0);
      chk_flit(0, 0, 0);
      // all channels requesting: strict 1,2,3 rotation until credits run out
      for (int i = 0; i < 24; i++) begin
         logic [2:0] oh;
         oh = i % 3 == 0 ? 3'b001 : i % 3 == 1 ? 3'b010 : 3'b100;
         cyc(3'b111, 3'b000, 1'b0, oh);
      end
      cyc(3'b111, 3'b000, 1'b0, 3'b000);
      chk_cred(0, 0, 0);
      chk_flit(8, 8, 8);
      // a credit returned to an empty channel is usable only the following cycle
      cyc(3'b010, 3'b010, 1'b0, 3'b000);
      cyc(3'b010, 3'b000, 1'b0, 3'b010);
      cyc(3'b010, 3'b000, 1'b0, 3'b000);
      chk_cred(0, 0, 0);
      for (int i = 0; i < 8; i++) cyc(3'b000, 3'b111, 1'b0, 3'b000);
      chk_cred(8, 8, 8);
      check("ovf_clear", {95'd0, cred_ovf}, 96'd0);
      cyc(3'b000, 3'b100, 1'b0, 3'b000);
      chk_cred(8, 8, 8);
      check("ovf_set", {95'd0, cred_ovf}, 96'd1);
      cyc(3'b000, 3'b000, 1'b0, 3'b000);
      check("ovf_hold", {95'd0, cred_ovf}, 96'd1);
      // last grant was channel 2, so channel 3 leads
      cyc(3'b101, 3'b000, 1'b0, 3'b100);
      cyc(3'b101, 3'b000, 1'b0, 3'b001);
      cyc(3'b101, 3'b000, 1'b0, 3'b100);
      cyc(3'b101, 3'b000, 1'b0, 3'b001);
      chk_cred(6, 8, 6);
      for (int i = 0; i < 6; i++) cyc(3'b001, 3'b001, 1'b0, 3'b001);
      chk_cred(6, 8, 6);
      // reset with a grant in flight
      cyc(3'b001, 3'b000, 1'b0, 3'b001);
      cyc(3'b001, 3'b111, 1'b1, 3'b000);
      chk_cred(8, 8, 8);
      check("ovf_rst", {95'd0, cred_ovf}, 96'd0);
      chk_flit(0, 0, 0);
      cyc(3'b111, 3'b000, 1'b0, 3'b001);
      for (int i = 0; i < 5; i++) cyc(3'b101, 3'b000, 1'b0, i % 2 == 0 ? 3'b100 : 3'b001);
      cyc(3'b001, 3'b000, 1'b0, 3'b001);
      cyc(3'b001, 3'b000, 1'b0, 3'b001);
      cyc(3'b000, 3'b000, 1'b0, 3'b000);
      chk_cred(3, 8, 5);
      chk_flit(5, 0, 3);
      @(negedge clk);
      #1;
      check("queue_drained", {64'd0, 32'(expq.size())}, 96'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
